// File: rtl/if_cfg_dispatch_if.sv
// ============================================================================
// Module   : if_cfg_dispatch_if
// Purpose  : Request, configuration-word and target-bus signals between the
//            controller, the config-word source and the two unit ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_cfg_dispatch_if #(
  parameter int WIDTH_PID  = 6,
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_LEN  = 8
);
  // connection request from the controller
  logic                  I_Req;
  logic [WIDTH_PID-1:0]  I_PDstID;
  logic [WIDTH_PID-1:0]  I_PSrcID;
  logic                  I_SelDst;
  logic [WIDTH_LEN-1:0]  I_Len;
  logic                  O_Ack;

  // incoming configuration words
  logic                  I_CfgValid;
  logic [WIDTH_DATA-1:0] I_CfgData;
  logic                  O_CfgReady;

  // destination-unit bus
  logic                  O_DstValid;
  logic [WIDTH_DATA-1:0] O_DstData;
  logic                  I_DstReady;

  // source-unit bus
  logic                  O_SrcValid;
  logic [WIDTH_DATA-1:0] O_SrcData;
  logic                  I_SrcReady;

  // status toward the controller
  logic [WIDTH_PID-1:0]  O_TgtID;
  logic                  O_Busy;
  logic                  O_Done;

  // dispatcher side
  modport slave (
    input  I_Req, I_PDstID, I_PSrcID, I_SelDst, I_Len,
    input  I_CfgValid, I_CfgData, I_DstReady, I_SrcReady,
    output O_Ack, O_CfgReady, O_DstValid, O_DstData,
    output O_SrcValid, O_SrcData, O_TgtID, O_Busy, O_Done
  );

  // controller / word source / unit side
  modport master (
    output I_Req, I_PDstID, I_PSrcID, I_SelDst, I_Len,
    output I_CfgValid, I_CfgData, I_DstReady, I_SrcReady,
    input  O_Ack, O_CfgReady, O_DstValid, O_DstData,
    input  O_SrcValid, O_SrcData, O_TgtID, O_Busy, O_Done
  );
endinterface

`default_nettype wire

// File: rtl/if_cfg_dispatch.sv
// ============================================================================
// Module   : if_cfg_dispatch
// Purpose  : Latches a connection request, then streams a fixed-length burst
//            of configuration words through one registered output stage to
//            either the destination unit (SelDst=1) or the source unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_cfg_dispatch #(
  parameter int WIDTH_PID  = 6,
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_LEN  = 8
) (
  input wire          clock,
  input wire          reset,
  if_cfg_dispatch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CFG   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  logic                  sel;
  logic [WIDTH_PID-1:0]  tgt;
  logic [WIDTH_LEN-1:0]  rem;
  logic                  ack;
  logic                  busy;
  logic                  done;

  logic                  out_valid;
  logic [WIDTH_DATA-1:0] out_data;

  logic                  tgt_ready;
  logic                  cfg_ready;
  logic                  accept;
  logic                  handshake;

  // Handshake decode: a word may enter while the stage is empty or draining.
  always_comb begin
    tgt_ready = sel ? bus.I_DstReady : bus.I_SrcReady;
    cfg_ready = (state == CFG) & (~out_valid | tgt_ready);
    accept    = bus.I_CfgValid & cfg_ready;
    handshake = out_valid & tgt_ready;
  end

  // Control FSM; Ack/Busy/Done are registered alongside the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel   <= 1'b0;
      tgt   <= '0;
      rem   <= '0;
      ack   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      ack  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.I_Req) begin
            sel  <= bus.I_SelDst;
            tgt  <= bus.I_SelDst ? bus.I_PDstID : bus.I_PSrcID;
            rem  <= bus.I_Len;
            ack  <= 1'b1;
            busy <= 1'b1;
            if (bus.I_Len != '0) begin
              state <= CFG;
            end else begin
              // empty burst: Ack and Done land in the same cycle
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        CFG: begin
          if (accept) begin
            // counter never wraps below zero
            if (rem != '0) begin
              rem <= rem - WIDTH_LEN'(1);
            end
            if (rem == WIDTH_LEN'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // finish once the last word has left (or leaves this cycle)
          if (!out_valid || tgt_ready) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Single output stage; a load in the drain cycle keeps valid asserted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= bus.I_CfgData;
    end else if (handshake) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.O_Ack      = ack;
  assign bus.O_Busy     = busy;
  assign bus.O_Done     = done;
  assign bus.O_TgtID    = tgt;
  assign bus.O_CfgReady = cfg_ready;
  assign bus.O_DstValid = out_valid & sel;
  assign bus.O_SrcValid = out_valid & ~sel;
  assign bus.O_DstData  = sel ? out_data : '0;
  assign bus.O_SrcData  = sel ? '0 : out_data;

endmodule

`default_nettype wire

// File: tb/tb_if_cfg_dispatch.sv
// ============================================================================
// Module   : tb_if_cfg_dispatch
// Purpose  : Scoreboard bench for if_cfg_dispatch. Stimulus pushes expected
//            words; a negedge monitor pops them on every target handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_cfg_dispatch;

  localparam int WIDTH_PID  = 6;
  localparam int WIDTH_DATA = 32;
  localparam int WIDTH_LEN  = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  if_cfg_dispatch_if #(
    .WIDTH_PID (WIDTH_PID),
    .WIDTH_DATA(WIDTH_DATA),
    .WIDTH_LEN (WIDTH_LEN)
  ) bus ();

  if_cfg_dispatch #(
    .WIDTH_PID (WIDTH_PID),
    .WIDTH_DATA(WIDTH_DATA),
    .WIDTH_LEN (WIDTH_LEN)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic                  sel;
    logic [WIDTH_DATA-1:0] data;
  } exp_t;

  exp_t                  exp_q[$];
  logic [WIDTH_DATA-1:0] feed_q[$];

  int   n_checks  = 0;
  int   n_errors  = 0;
  int   done_cnt  = 0;
  bit   feed_rand = 1'b0;
  bit   rdy_rand  = 1'b0;
  logic dst_rdy_cmd = 1'b1;
  logic src_rdy_cmd = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_req(input logic sel, input logic [WIDTH_PID-1:0] pdst,
                           input logic [WIDTH_PID-1:0] psrc, input logic [WIDTH_LEN-1:0] len);
    bus.I_Req    = 1'b1;
    bus.I_SelDst = sel;
    bus.I_PDstID = pdst;
    bus.I_PSrcID = psrc;
    bus.I_Len    = len;
  endtask

  // queue n words for the feeder and the matching expectations for the monitor
  task automatic load(input logic sel, input int n, input logic [WIDTH_DATA-1:0] base);
    for (int i = 0; i < n; i++) begin
      feed_q.push_back(base + WIDTH_DATA'(i));
      exp_q.push_back('{sel: sel, data: base + WIDTH_DATA'(i)});
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (bus.O_Done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    if (bus.O_Done !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: no O_Done within %0d cycles", name, budget);
    end
  endtask

  // Config-word source: presents the head of feed_q, pops it once taken.
  initial begin : feeder
    bit accepted;
    bus.I_CfgValid = 1'b0;
    bus.I_CfgData  = '0;
    forever begin
      @(negedge clock);
      accepted = bus.I_CfgValid && bus.O_CfgReady;
      @(posedge clock);
      #2;
      if (accepted && feed_q.size() > 0) void'(feed_q.pop_front());
      if (feed_q.size() > 0 && (!feed_rand || $urandom_range(0, 3) != 0)) begin
        bus.I_CfgValid = 1'b1;
        bus.I_CfgData  = feed_q[0];
      end else begin
        bus.I_CfgValid = 1'b0;
      end
    end
  end

  // Target ready drivers: directed level or random back-pressure.
  initial begin : ready_drv
    bus.I_DstReady = 1'b1;
    bus.I_SrcReady = 1'b1;
    forever begin
      @(posedge clock);
      #2;
      if (rdy_rand) begin
        bus.I_DstReady = 1'($urandom_range(0, 1));
        bus.I_SrcReady = 1'($urandom_range(0, 1));
      end else begin
        bus.I_DstReady = dst_rdy_cmd;
        bus.I_SrcReady = src_rdy_cmd;
      end
    end
  end

  // Monitor: scoreboard pops on each target handshake, plus bus invariants.
  initial begin : monitor
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bus.O_Done) begin
          done_cnt++;
          check("done_one_cycle", prev_done, 1'b0);
        end
        if (bus.O_DstValid)
          check("src_idle_during_dst", {bus.O_SrcValid, bus.O_SrcData}, '0);
        if (bus.O_SrcValid)
          check("dst_idle_during_src", {bus.O_DstValid, bus.O_DstData}, '0);
        if ((bus.O_DstValid && bus.I_DstReady) || (bus.O_SrcValid && bus.I_SrcReady)) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_word: got dst=%0b data=%0h, expected none",
                     bus.O_DstValid, bus.O_DstValid ? bus.O_DstData : bus.O_SrcData);
          end else begin
            e = exp_q.pop_front();
            check("word_bus_sel", bus.O_DstValid, e.sel);
            check("word_data", bus.O_DstValid ? bus.O_DstData : bus.O_SrcData, e.data);
          end
        end
      end
      prev_done = bus.O_Done;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // Directed sequences.
  initial begin : stim
    int  d0;
    bit  drain_seen;
    int  k;

    bus.I_Req    = 1'b0;
    bus.I_SelDst = 1'b0;
    bus.I_PDstID = '0;
    bus.I_PSrcID = '0;
    bus.I_Len    = '0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_busy",   bus.O_Busy, 0);
    check("rst_ack",    bus.O_Ack, 0);
    check("rst_done",   bus.O_Done, 0);
    check("rst_valids", {bus.O_DstValid, bus.O_SrcValid}, 0);
    check("rst_tgt",    bus.O_TgtID, 0);
    check("rst_cfgrdy", bus.O_CfgReady, 0);
    reset = 1'b0;
    tick();

    // ---- Len=3 to destination, everything ready ----
    d0 = done_cnt;
    load(1'b1, 3, 32'hA000_0000);
    tick();                                   // cycle 0
    start_req(1'b1, 6'd5, 6'd9, 8'd3);
    check("t1_c0_busy", bus.O_Busy, 0);
    tick();                                   // cycle 1
    check("t1_c1_ack",  bus.O_Ack, 1);
    check("t1_c1_busy", bus.O_Busy, 1);
    check("t1_c1_tgt",  bus.O_TgtID, 5);
    bus.I_Req = 1'b0;
    tick();                                   // cycle 2
    check("t1_c2_ack",  bus.O_Ack, 0);
    check("t1_c2_dst",  {bus.O_DstValid, bus.O_DstData}, {1'b1, 32'hA000_0000});
    tick();                                   // cycle 3
    check("t1_c3_dst",  {bus.O_DstValid, bus.O_DstData}, {1'b1, 32'hA000_0001});
    tick();                                   // cycle 4
    check("t1_c4_dst",  {bus.O_DstValid, bus.O_DstData}, {1'b1, 32'hA000_0002});
    check("t1_c4_done", bus.O_Done, 0);
    tick();                                   // cycle 5
    check("t1_c5_done", bus.O_Done, 1);
    check("t1_c5_dst",  bus.O_DstValid, 0);
    tick();                                   // cycle 6
    check("t1_c6_done", bus.O_Done, 0);
    check("t1_c6_busy", bus.O_Busy, 0);
    check("t1_tgt_hold", bus.O_TgtID, 5);
    check("t1_words_left", exp_q.size(), 0);
    check("t1_done_count", done_cnt - d0, 1);

    // ---- Len=2 to source, source stalls in cycles 2-4 ----
    d0 = done_cnt;
    load(1'b0, 2, 32'hB000_0000);
    tick();                                   // cycle 0
    start_req(1'b0, 6'd12, 6'd33, 8'd2);
    tick();                                   // cycle 1
    check("t2_c1_ack", bus.O_Ack, 1);
    check("t2_c1_tgt", bus.O_TgtID, 33);
    bus.I_Req = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      tick();
      if (c == 2) src_rdy_cmd = 1'b0;
      #2;
      check("t2_hold_src",    {bus.O_SrcValid, bus.O_SrcData}, {1'b1, 32'hB000_0000});
      check("t2_hold_cfgrdy", bus.O_CfgReady, 0);
      check("t2_hold_dst",    bus.O_DstValid, 0);
    end
    tick();                                   // cycle 5
    src_rdy_cmd = 1'b1;
    wait_done("t2", 20);
    tick();
    check("t2_words_left", exp_q.size(), 0);
    check("t2_done_count", done_cnt - d0, 1);

    // ---- Len=0: Ack and Done together, no words ----
    d0 = done_cnt;
    tick();                                   // cycle 0
    start_req(1'b1, 6'd3, 6'd4, 8'd0);
    check("t3_c0_busy", bus.O_Busy, 0);
    tick();                                   // cycle 1
    check("t3_c1_ackdone", {bus.O_Ack, bus.O_Done, bus.O_Busy}, 3'b111);
    check("t3_c1_tgt", bus.O_TgtID, 3);
    bus.I_Req = 1'b0;
    tick();                                   // cycle 2
    check("t3_c2_idle", {bus.O_Ack, bus.O_Done, bus.O_Busy, bus.O_DstValid}, 4'b0000);
    check("t3_done_count", done_cnt - d0, 1);

    // ---- Len=255 with random valid and ready gaps ----
    d0 = done_cnt;
    feed_rand = 1'b1;
    rdy_rand  = 1'b1;
    load(1'b1, 255, 32'hC000_0000);
    tick();
    start_req(1'b1, 6'd17, 6'd18, 8'd255);
    tick();
    check("t4_ack", bus.O_Ack, 1);
    bus.I_Req = 1'b0;
    drain_seen = 1'b0;
    k = 0;
    while (bus.O_Done !== 1'b1 && k < 4000) begin
      @(posedge clock);
      #3;
      if (!drain_seen && feed_q.size() == 0) begin
        check("t4_cfgrdy_after_last", bus.O_CfgReady, 0);
        drain_seen = 1'b1;
      end
      k++;
    end
    if (bus.O_Done !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL t4_timeout: no O_Done within %0d cycles", k);
    end
    check("t4_last_accept_seen", drain_seen, 1);
    feed_rand = 1'b0;
    rdy_rand  = 1'b0;
    tick();
    tick();
    check("t4_words_left", exp_q.size(), 0);
    check("t4_done_count", done_cnt - d0, 1);

    // ---- Request while busy is ignored until IDLE ----
    d0 = done_cnt;
    load(1'b1, 4, 32'hD000_0000);
    tick();                                   // cycle 0
    start_req(1'b1, 6'd7, 6'd8, 8'd4);
    tick();                                   // cycle 1
    check("t5_ack1", bus.O_Ack, 1);
    check("t5_tgt1", bus.O_TgtID, 7);
    bus.I_Req = 1'b0;
    tick();                                   // cycle 2
    start_req(1'b0, 6'd20, 6'd21, 8'd1);
    load(1'b0, 1, 32'hE000_0000);
    k = 0;
    while (bus.O_Done !== 1'b1 && k < 20) begin
      check("t5_busy_tgt", {bus.O_Ack, bus.O_TgtID}, {1'b0, 6'd7});
      tick();
      k++;
    end
    check("t5_done_tgt", {bus.O_Done, bus.O_TgtID}, {1'b1, 6'd7});
    tick();                                   // IDLE, request captured here
    check("t5_idle_noack", bus.O_Ack, 0);
    tick();
    check("t5_ack2", bus.O_Ack, 1);
    check("t5_tgt2", bus.O_TgtID, 21);
    bus.I_Req = 1'b0;
    wait_done("t5", 20);
    tick();
    check("t5_words_left", exp_q.size(), 0);
    check("t5_done_count", done_cnt - d0, 2);

    // ---- Async reset with a word held in the output stage ----
    load(1'b1, 3, 32'hF000_0000);
    tick();                                   // cycle 0
    start_req(1'b1, 6'd11, 6'd12, 8'd3);
    dst_rdy_cmd = 1'b0;
    tick();                                   // cycle 1
    check("t6_ack", bus.O_Ack, 1);
    bus.I_Req = 1'b0;
    tick();                                   // cycle 2
    check("t6_held", {bus.O_DstValid, bus.O_DstData}, {1'b1, 32'hF000_0000});
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    check("t6_rst_valid", {bus.O_DstValid, bus.O_SrcValid}, 0);
    check("t6_rst_data",  {bus.O_DstData, bus.O_SrcData}, 0);
    check("t6_rst_ctrl",  {bus.O_Ack, bus.O_Busy, bus.O_Done, bus.O_CfgReady}, 0);
    check("t6_rst_tgt",   bus.O_TgtID, 0);
    exp_q.delete();
    feed_q.delete();
    dst_rdy_cmd = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_idle", bus.O_Busy, 0);
    d0 = done_cnt;
    load(1'b1, 1, 32'h1234_5678);
    tick();
    start_req(1'b1, 6'd2, 6'd3, 8'd1);
    tick();
    check("t6_ack2", bus.O_Ack, 1);
    bus.I_Req = 1'b0;
    wait_done("t6", 20);
    tick();
    check("t6_words_left", exp_q.size(), 0);
    check("t6_done_count", done_cnt - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_cfg_dispatch.md
Name: if_cfg_dispatch

Overview:
- Sits directly downstream of the interface access-pattern detector in the BRAM/IF unit.
- Latches a connection request (physical destination ID, physical source ID, Destination-Select), then streams a fixed-length burst of configuration words to the selected unit.
- SelDst=1 routes the burst to the destination unit; SelDst=0 routes it to the source unit.
- Provides one registered output stage with valid/ready handshakes and request/completion signalling to the controller.

Parameters:
WIDTH_PID, 6, physical unit-ID width (matches package value)
WIDTH_DATA, 32, configuration word width
WIDTH_LEN, 8, burst-length width; max burst = 2^WIDTH_LEN-1 words

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
I_Req  in  1  connection request; requester holds it high until O_Ack
I_PDstID  in  WIDTH_PID  physical destination index
I_PSrcID  in  WIDTH_PID  physical source index
I_SelDst  in  1  destination-select from pattern detector (same-cycle with IDs)
I_Len  in  WIDTH_LEN  number of config words in burst
O_Ack  out  1  request accepted, 1-cycle pulse
I_CfgValid  in  1  config word valid
I_CfgData  in  WIDTH_DATA  config word
O_CfgReady  out  1  config word accepted when high with I_CfgValid
O_DstValid  out  1  word valid toward destination unit
O_DstData  out  WIDTH_DATA  word toward destination unit
I_DstReady  in  1  destination unit ready
O_SrcValid  out  1  word valid toward source unit
O_SrcData  out  WIDTH_DATA  word toward source unit
I_SrcReady  in  1  source unit ready
O_TgtID  out  WIDTH_PID  physical ID of unit being configured
O_Busy  out  1  high in every state except IDLE
O_Done  out  1  burst complete, 1-cycle pulse

Behaviour:
- Reset: async, active-high. All outputs 0, state IDLE, counter 0, output register empty. Reset mid-burst discards any held word; no O_Done is issued.

FSM states: IDLE, CFG, DRAIN, DONE.
- IDLE:
  - On I_Req=1, capture sel=I_SelDst, tgt=(I_SelDst ? I_PDstID : I_PSrcID), rem=I_Len.
  - Go to CFG if I_Len!=0, else DONE.
- CFG:
  - O_CfgReady = ~out_valid | tgt_ready, where tgt_ready = sel ? I_DstReady : I_SrcReady.
  - Accept = I_CfgValid & O_CfgReady: load output register, decrement rem.
  - Accept with rem==1 goes to DRAIN.
- DRAIN:
  - O_CfgReady=0.
  - Go to DONE when the output register is empty or its handshake completes this cycle.
- DONE: O_Done=1 for this cycle only; next state IDLE.

Ack and request rules:
- O_Ack is registered: high exactly in the first cycle after capture (the first CFG or DONE cycle).
- I_Req is ignored outside IDLE.
- I_Req still high in the Ack cycle is not a new request; the requester must drop it after seeing O_Ack.

Output register:
- Single stage; word accepted in cycle N is visible in cycle N+1.
- With ready held high, throughput is 1 word/cycle.
- out_valid clears on handshake unless reloaded the same cycle (simultaneous drain and load keeps valid=1 with the new data).
- O_DstValid = out_valid & sel; O_SrcValid = out_valid & ~sel.
- The selected bus carries out_data; the non-selected data bus is driven 0.
- Held data and valid stay stable while the selected ready is low.

Other outputs:
- O_TgtID holds the captured target from capture until the next capture.
- The counter is WIDTH_LEN wide with no wrap: decrement occurs only when rem>0.

Test Plan:
- Len=3, SelDst=1, PDstID=5, PSrcID=9, CfgValid and DstReady held high, data A,B,C; Req at cycle 0 -> Ack cycle 1; O_DstValid cycles 2-4 with A,B,C; O_Done cycle 5; O_SrcValid never high; O_TgtID=5.
- Len=2, SelDst=0, SrcReady low cycles 2-4 -> O_SrcValid/O_SrcData held stable, O_CfgReady=0 while full; both words delivered in order; O_TgtID=PSrcID; O_DstValid stays 0.
- Len=0 -> Ack and O_Done both in cycle 1, no word output, O_Busy high only in cycle 1.
- Len=255, random CfgValid/ready gaps -> exactly 255 words out in order, O_Done once, O_CfgReady=0 after the 255th accept.
- Second Req with different IDs while busy -> ignored; O_TgtID unchanged until the first burst's Done; a new Req in IDLE is then accepted.
- Reset asserted mid-burst with a word held in the output register -> all outputs 0 immediately (async), no O_Done; a fresh Len=1 request after reset completes normally.
